// File: rtl/imem_loader_ctrl.sv
// Loads the instruction memory from a byte stream, packing four little-endian
// bytes per 32-bit word, and holds the core in reset while a load runs.
module imem_loader_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   num_words,
    input  logic          abort,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_wa,
    output logic [31:0]   mem_wd,
    output logic          core_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [AW:0] r_word_cnt;
    logic [AW:0] r_count;
    logic [31:0] r_buf;
    logic        r_hold;
    logic        r_err;

    logic        w_accept;
    logic        w_last_word;
    logic        w_count_ok;

    assign w_accept    = rx_valid && rx_ready;
    assign w_last_word = (r_word_cnt == (r_count - (AW+1)'(1)));
    assign w_count_ok  = (num_words != '0) && (num_words <= DEPTH_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_count    <= '0;
            r_buf      <= '0;
            r_hold     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_count_ok) begin
                            r_count    <= num_words;
                            r_byte_cnt <= '0;
                            r_word_cnt <= '0;
                            r_hold     <= 1'b1;
                            r_state    <= S_RECV;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (abort) begin
                        // core_hold is left set: memory now holds a partial program
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        r_buf[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_word_cnt <= r_word_cnt + (AW+1)'(1);
                        if (w_last_word) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_byte_cnt <= '0;
                            r_state    <= S_RECV;
                        end
                    end
                end
                S_FINISH: begin
                    r_hold  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // abort acts within its own cycle so a colliding byte or write is dropped
    assign rx_ready  = (r_state == S_RECV) && !abort;
    assign mem_we    = (r_state == S_WRITE) && !abort;
    assign mem_wa    = r_word_cnt[AW-1:0];
    assign mem_wd    = r_buf;
    assign core_hold = r_hold;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FINISH);
    assign err       = r_err;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed and randomized bench for imem_loader_ctrl; expected memory writes
// are derived from the transmitted byte list.
module tb_imem_loader_ctrl;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset, start, abort, rx_valid;
    logic [AW:0]   num_words;
    logic [7:0]    rx_data;
    logic          rx_ready, mem_we, core_hold, busy, done, err;
    logic [AW-1:0] mem_wa;
    logic [31:0]   mem_wd;

    imem_loader_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .abort(abort), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .core_hold(core_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, written only by this monitor
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int done_cnt = 0, err_cnt = 0, viol = 0, done_cyc = 0;
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_wa);
            wr_data.push_back(mem_wd);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (err) err_cnt = err_cnt + 1;
        if ((mem_we && (!busy || rx_ready)) || (busy && !core_hold) || (rx_ready && !busy))
            viol = viol + 1;
    end

    int tests = 0, failed = 0;
    logic [7:0] tx_q[$];
    int start_cyc;
    int b_w, b_done, b_err, b_viol;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_w = wr_addr.size(); b_done = done_cnt; b_err = err_cnt; b_viol = viol;
    endtask

    task automatic fill_rand(input int nbytes);
        tx_q.delete();
        for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic do_start(input int n);
        num_words = (AW+1)'(n);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int gap);
        for (int i = lo; i < hi; i++) begin
            logic acc;
            int   k;
            rx_data  = tx_q[i];
            rx_valid = 1'b1;
            acc = 1'b0;
            k   = 0;
            while (!acc && k < 50) begin
                @(negedge clk);
                acc = rx_ready;
                tick();
                k++;
            end
            if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
            rx_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy && k < limit) begin
            tick();
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        tick();
    endtask

    // Reference: word i is bytes 4i..4i+3 little-endian, written to address i
    task automatic check_writes(input string tag, input int nw);
        chk({tag, "_nwrites"}, 32'(wr_addr.size() - b_w), 32'(nw));
        for (int i = 0; i < nw; i++) begin
            logic [31:0] exp_w;
            exp_w = 32'(tx_q[4*i]) + 32'(tx_q[4*i+1]) * 256
                  + 32'(tx_q[4*i+2]) * 65536 + 32'(tx_q[4*i+3]) * 16777216;
            if (b_w + i < wr_addr.size()) begin
                chk({tag, "_addr"}, 32'(wr_addr[b_w+i]), 32'(i));
                chk({tag, "_data"}, wr_data[b_w+i], exp_w);
            end
        end
    endtask

    task automatic full_load(input string tag, input int n, input int gap);
        snap();
        do_start(n);
        send_range(0, 4*n, gap);
        wait_idle(200 + 10*n);
        check_writes(tag, n);
        chk({tag, "_done"}, 32'(done_cnt - b_done), 32'd1);
        chk({tag, "_err"}, 32'(err_cnt - b_err), 32'd0);
        chk({tag, "_hold"}, 32'(core_hold), 32'd0);
        chk({tag, "_viol"}, 32'(viol - b_viol), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0;
        rx_data = '0; num_words = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_hold", 32'(core_hold), 0);
        chk("rst_rx_ready", 32'(rx_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_wa", 32'(mem_wa), 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_done_err", 32'({done, err}), 0);
        reset = 1'b0;
        tick();

        // Two-word program with rx_valid held high
        tx_q = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
        full_load("two_word", 2, 0);
        chk("two_word_done_latency", 32'(done_cyc - start_cyc), 32'd11);
        chk("two_word_w0", wr_data[b_w], 32'h00500113);
        chk("two_word_w1", wr_data[b_w+1], 32'h00C00193);

        // One word with 2-cycle gaps between bytes
        tx_q = '{8'h63, 8'h88, 8'h72, 8'h02};
        full_load("gapped", 1, 2);
        chk("gapped_w0", wr_data[b_w], 32'h02728863);

        // Rejected starts
        snap();
        do_start(0);
        tick(); tick();
        do_start(65);
        tick(); tick();
        chk("badstart_err", 32'(err_cnt - b_err), 32'd2);
        chk("badstart_busy", 32'(busy), 0);
        chk("badstart_hold", 32'(core_hold), 0);
        chk("badstart_writes", 32'(wr_addr.size() - b_w), 0);

        // Abort while idle is ignored
        snap();
        abort = 1'b1; tick(); abort = 1'b0; tick(); tick();
        chk("idle_abort_err", 32'(err_cnt - b_err), 0);

        // Abort colliding with the 3rd byte of word 1
        fill_rand(12);
        snap();
        do_start(3);
        send_range(0, 6, 0);
        rx_data = tx_q[6]; rx_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("abort_rx_ready", 32'(rx_ready), 0);
        tick();
        abort = 1'b0; rx_valid = 1'b0;
        tick(); tick();
        check_writes("abort", 1);
        chk("abort_err", 32'(err_cnt - b_err), 32'd1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_hold", 32'(core_hold), 1);
        chk("abort_done", 32'(done_cnt - b_done), 0);
        fill_rand(4);
        full_load("post_abort", 1, 1);

        // Randomized loads
        for (int t = 0; t < 4; t++) begin
            int n, gap;
            n   = $urandom_range(1, 8);
            gap = $urandom_range(0, 3);
            fill_rand(4*n);
            full_load("rand", n, gap);
        end

        // Full-depth load
        fill_rand(4*DEPTH);
        full_load("full_depth", DEPTH, 0);

        // Reset in the middle of word 0
        fill_rand(4);
        do_start(1);
        send_range(0, 2, 0);
        reset = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_hold", 32'(core_hold), 0);
        chk("midrst_rx_ready", 32'(rx_ready), 0);
        chk("midrst_mem_we", 32'(mem_we), 0);
        chk("midrst_mem_wa", 32'(mem_wa), 0);
        chk("midrst_mem_wd", mem_wd, 0);
        chk("midrst_done_err", 32'({done, err}), 0);
        reset = 1'b0;
        tick();
        fill_rand(4);
        full_load("after_rst", 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/imem_loader_ctrl.md
Name: imem_loader_ctrl

Overview:
Sequencing controller that programs the 64-word instruction memory from an 8-bit byte stream (e.g. a UART receiver). It packs four little-endian bytes into each 32-bit instruction and writes the words to consecutive word addresses starting at 0. While a load is in progress, it holds the single-cycle core in reset, so the core never fetches partially written memory.

Parameters:
DEPTH, 64, number of 32-bit words in the instruction memory
AW, 6, word-address width (log2 DEPTH)

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that opens a load session (sampled only in IDLE)
num_words  in  AW+1  number of words to load; valid range 1..DEPTH; sampled with start
abort  in  1  cancels an in-progress session
rx_valid  in  1  byte available on rx_data
rx_data  in  8  incoming program byte
rx_ready  out  1  controller accepts a byte this cycle
mem_we  out  1  instruction-memory write enable
mem_wa  out  AW  word address of the write
mem_wd  out  32  instruction word to write
core_hold  out  1  holds the core in reset while high
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a session completes successfully
err  out  1  one-cycle pulse on a rejected start or an abort

Behaviour:
- Reset: go to IDLE and clear the byte counter, word counter and word buffer.
  - All outputs are 0 after reset, including core_hold. mem_wa and mem_wd are also 0.
- States: IDLE, RECV, WRITE, FINISH.
- IDLE:
  - start with num_words in 1..DEPTH: latch the count, clear both counters, go to RECV.
  - start with num_words = 0 or > DEPTH: err = 1 for the next cycle; stay in IDLE; core_hold unchanged.
- RECV:
  - rx_ready = 1 exactly when (state == RECV) and abort is low.
  - A byte is accepted on rx_valid && rx_ready. Byte number k (k = 0..3) goes into buffer bits [8k+7:8k]; byte_cnt then increments.
  - Acceptance of the 4th byte moves the FSM to WRITE on the next edge.
  - rx_valid low leaves the state unchanged; there is no timeout.
- WRITE:
  - Lasts exactly one cycle, with rx_ready = 0 and mem_we = 1.
  - mem_wa = word_cnt and mem_wd = the assembled word.
  - Then word_cnt increments. If the written word was number count-1, go to FINISH; otherwise clear byte_cnt and return to RECV.
- FINISH:
  - Lasts one cycle with done = 1.
  - Next state is IDLE; core_hold drops on that edge.
- core_hold:
  - Set on entry to RECV. Stays high through WRITE and FINISH.
  - Cleared only on the FINISH -> IDLE transition or by reset.
- abort:
  - Abort in RECV or WRITE: go to IDLE with err pulsed next cycle.
  - Abort has priority over a same-cycle byte, which is not accepted.
  - Abort in WRITE suppresses mem_we that cycle.
  - After abort, core_hold stays high (sticky): memory contents are partial. Only a completed load or reset releases it.
  - Abort in IDLE or FINISH is ignored.
- start outside IDLE is ignored.
- mem_we is never high outside WRITE.
- Throughput is at most 1 word per 5 cycles when rx_valid is held high.
- Addresses never wrap, because count <= DEPTH is enforced at start.
- Reset mid-session: immediate IDLE with all outputs at 0. Words already written are not reverted.

Test Plan:
- start with num_words=2, then bytes 13 01 50 00 93 01 C0 00 with rx_valid held high -> writes 0x00500113 to addr 0 and 0x00C00193 to addr 1, one mem_we cycle each; done pulses 11 cycles after start; core_hold high from cycle 1 through done, then low.
- start with num_words=1, bytes fed with 2-cycle gaps (rx_valid low between bytes) -> no byte lost or duplicated; word 0x02728863 at addr 0; rx_ready high only in RECV.
- start with num_words=0, then with num_words=65 -> err pulses once each; busy, core_hold and mem_we stay 0.
- start with num_words=3; abort asserted in the same cycle as the 3rd byte of word 1 -> that byte is not accepted; only addr 0 is written; err pulses; busy drops; core_hold stays 1. A following full 1-word load clears core_hold.
- start with num_words=64 and 256 bytes -> addresses 0..63 written in order; mem_wa never wraps; done pulses once.
- Reset asserted mid-RECV after 2 bytes -> the next cycle shows all outputs 0 and state IDLE; a fresh load starts from addr 0, byte 0.
